// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - CNN accelerator layer sequencer
// Loads FM and weights, then walks a parameter layer table one handshake at a time under a watchdog.
module cnn_layer_sequencer #(
    parameter int                        NUM_LAYERS      = 5,
    parameter int                        LAYER_NUM_WIDTH = 3,
    parameter logic [2*NUM_LAYERS-1:0]   LAYER_TYPES     = 10'b11_10_01_01_00,
    parameter int                        TIMEOUT_WIDTH   = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       init_fm_data_done,
    input  logic                       weight_data_done,
    input  logic                       layer_done,
    output logic                       init,
    output logic                       layer_start,
    output logic [LAYER_NUM_WIDTH-1:0] layer_num,
    output logic [1:0]                 layer_type,
    output logic [1:0]                 pre_layer_type,
    output logic                       busy,
    output logic                       net_done,
    output logic                       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ISSUE,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [LAYER_NUM_WIDTH-1:0] LAST_LAYER = LAYER_NUM_WIDTH'(NUM_LAYERS - 1);
    localparam logic [LAYER_NUM_WIDTH-1:0] ONE_LAYER  = LAYER_NUM_WIDTH'(1);

    state_t                       state_q;
    logic                         start_q;
    logic                         fm_q;
    logic                         wt_q;
    logic [TIMEOUT_WIDTH-1:0]     wd_q;
    logic                         init_q;
    logic                         layer_start_q;
    logic [LAYER_NUM_WIDTH-1:0]   layer_num_q;
    logic [1:0]                   layer_type_q;
    logic [1:0]                   pre_type_q;
    logic                         busy_q;
    logic                         net_done_q;
    logic                         timeout_q;

    logic                         go;
    logic                         fm_d;
    logic                         wt_d;
    logic [TIMEOUT_WIDTH-1:0]     wd_d;
    logic                         wd_term;
    logic [LAYER_NUM_WIDTH-1:0]   layer_num_d;

    function automatic logic [1:0] type_of(input logic [LAYER_NUM_WIDTH-1:0] idx);
        logic [2*NUM_LAYERS-1:0] sh;
        sh = LAYER_TYPES >> {idx, 1'b0};
        return sh[1:0];
    endfunction

    assign go          = start & ~start_q;
    assign fm_d        = fm_q | init_fm_data_done;
    assign wt_d        = wt_q | weight_data_done;
    assign wd_d        = wd_q + TIMEOUT_WIDTH'(1);
    assign wd_term     = (wd_d == '1);
    assign layer_num_d = layer_num_q + ONE_LAYER;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            // Sampling start here means a level held through reset is not mistaken for a new edge.
            start_q       <= start;
            fm_q          <= 1'b0;
            wt_q          <= 1'b0;
            wd_q          <= '0;
            init_q        <= 1'b0;
            layer_start_q <= 1'b0;
            layer_num_q   <= '0;
            layer_type_q  <= 2'd0;
            pre_type_q    <= 2'd0;
            busy_q        <= 1'b0;
            net_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            start_q       <= start;
            init_q        <= 1'b0;
            layer_start_q <= 1'b0;
            net_done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q      <= S_LOAD;
                        init_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        layer_num_q  <= '0;
                        layer_type_q <= type_of('0);
                        pre_type_q   <= 2'd0;
                        timeout_q    <= 1'b0;
                        fm_q         <= 1'b0;
                        wt_q         <= 1'b0;
                        wd_q         <= '0;
                    end
                end
                S_LOAD: begin
                    fm_q <= fm_d;
                    wt_q <= wt_d;
                    wd_q <= wd_d;
                    if (fm_d && wt_d) begin
                        state_q      <= S_CHECK;
                        layer_num_q  <= ONE_LAYER;
                        layer_type_q <= type_of(ONE_LAYER);
                        pre_type_q   <= 2'd0;
                    end else if (wd_term) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    state_q <= (layer_type_q == 2'd0) ? S_NEXT : S_ISSUE;
                end
                S_ISSUE: begin
                    state_q       <= S_RUN;
                    layer_start_q <= 1'b1;
                    wd_q          <= '0;
                end
                S_RUN: begin
                    wd_q <= wd_d;
                    // A completion on the terminal-count cycle still counts as success.
                    if (layer_done) begin
                        state_q    <= S_NEXT;
                        pre_type_q <= layer_type_q;
                    end else if (wd_term) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (layer_num_q == LAST_LAYER) begin
                        state_q    <= S_DONE;
                        net_done_q <= 1'b1;
                    end else begin
                        state_q      <= S_CHECK;
                        layer_num_q  <= layer_num_d;
                        layer_type_q <= type_of(layer_num_d);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign init           = init_q;
    assign layer_start    = layer_start_q;
    assign layer_num      = layer_num_q;
    assign layer_type     = layer_type_q;
    assign pre_layer_type = pre_type_q;
    assign busy           = busy_q;
    assign net_done       = net_done_q;
    assign timeout_err    = timeout_q;

endmodule
